// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// 32-iteration shift-add multiply and restoring divide, with sign fix-up in FIN.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div, neg_q, neg_r;
  logic [31:0] opd;   // multiplicand or divisor magnitude
  logic [63:0] acc;   // mul: {partial, multiplier}; div: [31:0] dividend -> quotient
  logic [31:0] rem;

  // Signed ops are the even encodings 0 (MULT) and 2 (DIV)
  logic        is_signed, sa, sb;
  logic [31:0] abs_a, abs_b;
  assign is_signed = ~req_op[0];
  assign sa        = is_signed & req_a[31];
  assign sb        = is_signed & req_b[31];
  assign abs_a     = sa ? (~req_a + 32'd1) : req_a;
  assign abs_b     = sb ? (~req_b + 32'd1) : req_b;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        no_sub;
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
  assign div_shift = {rem, acc[31]};
  assign no_sub    = div_shift < {1'b0, opd};
  // True difference is below the divisor, so 32 bits hold it exactly
  assign div_diff  = div_shift[31:0] - opd;

  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;
  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign q_fix    = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign r_fix    = neg_r ? (~rem + 32'd1) : rem;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN) && !cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opd    <= 32'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
    end else if (cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (req_op == OP_MTHI) hi <= req_a;
          else if (req_op == OP_MTLO) lo <= req_a;
          else if (req_op[2] == 1'b0) begin
            is_div <= req_op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            cnt    <= 5'd0;
            rem    <= 32'd0;
            opd    <= req_op[1] ? abs_b : abs_a;
            acc    <= {32'd0, req_op[1] ? abs_a : abs_b};
            state  <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            rem        <= no_sub ? div_shift[31:0] : div_diff;
            acc[31:0]  <= {acc[30:0], ~no_sub};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIN;
        end
        FIN: begin
          if (is_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: results, latency, cancel, reset and handshake.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, cancel, busy, done;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, hi, lo;
  int          pass_cnt = 0;
  int          total = 0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Called #1 after an edge with the DUT idle; returns in the first idle cycle after the op.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int done_at, output int busy_n, output int done_n);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    done_at = -1; busy_n = 0; done_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = k; end
      if (!busy) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; cancel = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else pass_cnt++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b exp 00", busy, done); else pass_cnt++;
    total++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); else pass_cnt++;
  endtask

  task automatic test_multu;
    int da, bn, dn;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, da, bn, dn);
    total++; if (da !== 33 || dn !== 1) $display("FAIL multu_done got cyc %0d n %0d exp 33/1", da, dn); else pass_cnt++;
    total++; if (bn !== 33) $display("FAIL multu_busy got %0d exp 33", bn); else pass_cnt++;
    total++; if (req_ready !== 1'b1) $display("FAIL multu_ready got %b exp 1", req_ready); else pass_cnt++;
    total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) $display("FAIL multu_res got %h/%h exp fffffffe/00000001", hi, lo); else pass_cnt++;
  endtask

  task automatic test_mult;
    int da, bn, dn;
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, da, bn, dn);
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) $display("FAIL mult_neg got %h/%h exp ffffffff/ffffffeb", hi, lo); else pass_cnt++;
    run_op(3'd0, 32'h80000000, 32'h80000000, da, bn, dn);
    total++; if (hi !== 32'h40000000 || lo !== 32'h0) $display("FAIL mult_min got %h/%h exp 40000000/00000000", hi, lo); else pass_cnt++;
  endtask

  task automatic test_div;
    int da, bn, dn;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, da, bn, dn);
    total++; if (da !== 33) $display("FAIL div_done got %0d exp 33", da); else pass_cnt++;
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) $display("FAIL div_neg got lo %h hi %h exp fffffffd/ffffffff", lo, hi); else pass_cnt++;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, da, bn, dn);
    total++; if (lo !== 32'h80000000 || hi !== 32'h0) $display("FAIL div_ovf got lo %h hi %h exp 80000000/00000000", lo, hi); else pass_cnt++;
    run_op(3'd3, 32'd100, 32'd7, da, bn, dn);
    total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu got lo %h hi %h exp 0000000e/00000002", lo, hi); else pass_cnt++;
  endtask

  task automatic test_div_zero;
    int da, bn, dn;
    run_op(3'd3, 32'h12345678, 32'd0, da, bn, dn);
    total++; if (lo !== 32'hFFFFFFFF || hi !== 32'h12345678) $display("FAIL divu0 got lo %h hi %h exp ffffffff/12345678", lo, hi); else pass_cnt++;
    run_op(3'd2, 32'hFFFFFFF0, 32'd0, da, bn, dn);
    total++; if (lo !== 32'h00000001 || hi !== 32'hFFFFFFF0) $display("FAIL div0_neg got lo %h hi %h exp 00000001/fffffff0", lo, hi); else pass_cnt++;
    run_op(3'd2, 32'd9, 32'd0, da, bn, dn);
    total++; if (lo !== 32'hFFFFFFFF || hi !== 32'd9) $display("FAIL div0_pos got lo %h hi %h exp ffffffff/00000009", lo, hi); else pass_cnt++;
  endtask

  task automatic test_mt_cancel;
    int seen_done = 0;
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    total++; if (hi !== 32'hA5A5A5A5 || busy !== 1'b0) $display("FAIL mthi got %h busy %b exp a5a5a5a5/0", hi, busy); else pass_cnt++;
    req_op = 3'd5; req_a = 32'h5A5A5A5A;
    @(posedge clk); #1;
    total++; if (lo !== 32'h5A5A5A5A || hi !== 32'hA5A5A5A5 || busy !== 1'b0) $display("FAIL mtlo got %h/%h busy %b exp a5a5a5a5/5a5a5a5a/0", hi, lo, busy); else pass_cnt++;
    req_op = 3'd3; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin
      if (done) seen_done++;
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL cancel_run got busy %b done %b exp 1/0", busy, done); else pass_cnt++;
    @(posedge clk); #1;
    cancel = 1'b0;
    total++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL cancel_idle got ready %b busy %b exp 1/0", req_ready, busy); else pass_cnt++;
    repeat (30) begin
      if (done) seen_done++;
      @(posedge clk); #1;
    end
    total++; if (seen_done !== 0) $display("FAIL cancel_done got %0d pulses exp 0", seen_done); else pass_cnt++;
    total++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) $display("FAIL cancel_hilo got %h/%h exp a5a5a5a5/5a5a5a5a", hi, lo); else pass_cnt++;
  endtask

  task automatic test_hold_valid;
    int ready_hi = 0;
    int busy_n = 0;
    req_valid = 1'b1; req_op = 3'd1; req_a = 32'd3; req_b = 32'd5;
    @(posedge clk); #1;
    for (int k = 1; k <= 33; k++) begin
      if (req_ready) ready_hi++;
      if (k == 33) begin
        total++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL hold_fin got done %b busy %b exp 1/1", done, busy); else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    total++; if (ready_hi !== 0) $display("FAIL hold_ready_busy got %0d exp 0", ready_hi); else pass_cnt++;
    total++; if (req_ready !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) $display("FAIL hold_t34 got ready %b %h/%h exp 1 00000000/0000000f", req_ready, hi, lo); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy %b exp 1", busy); else pass_cnt++;
    for (int k = 0; k < 40 && busy; k++) begin
      busy_n++;
      @(posedge clk); #1;
    end
    total++; if (busy_n !== 33 || lo !== 32'd15) $display("FAIL b2b_result got busy %0d lo %h exp 33/0000000f", busy_n, lo); else pass_cnt++;
  endtask

  task automatic test_cancel_idle;
    req_valid = 1'b1; cancel = 1'b1; req_op = 3'd4; req_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    total++; if (hi !== 32'd0) $display("FAIL cancel_mthi got %h exp 00000000", hi); else pass_cnt++;
    req_op = 3'd1; req_a = 32'd2; req_b = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0; cancel = 1'b0;
    total++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL cancel_mul_drop got busy %b ready %b exp 0/1", busy, req_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'h11112222;
    @(posedge clk); #1;
    req_op = 3'd1; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    total++; if (busy !== 1'b1 || hi !== 32'h11112222) $display("FAIL pre_reset got busy %b hi %h exp 1/11112222", busy, hi); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL reset_mid got %h/%h busy %b ready %b exp 0/0/0/1", hi, lo, busy, req_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_mt_cancel;
    test_hold_valid;
    test_cancel_idle;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
